// File: rtl/branch_resolve_unit_if.sv
// Bundle between EX/fetch and the branch resolve unit: prediction lookup,
// resolve handshake, redirect handshake, flush and mispredict statistics.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken;
  logic            resolve_valid;
  logic            resolve_ready;
  logic [XLEN-1:0] resolve_pc;
  logic [XLEN-1:0] resolve_target;
  logic            is_branch;
  logic            is_jump;
  logic            cmp_result;
  logic            predicted_taken;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     mispredict_count;

  modport master (
    output fetch_pc, resolve_valid, resolve_pc, resolve_target, is_branch,
           is_jump, cmp_result, predicted_taken, redirect_ready,
    input  predict_taken, resolve_ready, redirect_valid, redirect_pc, flush,
           mispredict_count
  );

  modport slave (
    input  fetch_pc, resolve_valid, resolve_pc, resolve_target, is_branch,
           is_jump, cmp_result, predicted_taken, redirect_ready,
    output predict_taken, resolve_ready, redirect_valid, redirect_pc, flush,
           mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in EX against the fetch prediction, issues a registered
// PC redirect plus pipeline flush on mispredict, and owns a 2-bit saturating BHT.
module branch_resolve_unit #(
  parameter int XLEN            = 32,
  parameter int BHT_INDEX_WIDTH = 6,
  parameter int FLUSH_CYCLES    = 2
) (
  input logic               clk,
  input logic               rst,
  branch_resolve_unit_if.slave bus
);
  localparam int BHT_DEPTH = 1 << BHT_INDEX_WIDTH;
  localparam int CNT_WIDTH = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  state_t                     state, state_d;
  logic [1:0]                 bht [BHT_DEPTH];
  logic                       redirect_valid, redirect_valid_d;
  logic [XLEN-1:0]            redirect_pc, redirect_pc_d;
  logic                       flush, flush_d;
  logic [31:0]                count, count_d;
  logic [CNT_WIDTH-1:0]       flush_cnt, flush_cnt_d;

  logic [BHT_INDEX_WIDTH-1:0] fetch_idx, resolve_idx;
  logic                       accept, actual, mispredict, train;
  logic [XLEN-1:0]            correct_pc;
  logic [1:0]                 bht_cur, bht_next;

  assign fetch_idx   = bus.fetch_pc[BHT_INDEX_WIDTH+1:2];
  assign resolve_idx = bus.resolve_pc[BHT_INDEX_WIDTH+1:2];

  assign bus.predict_taken    = bht[fetch_idx][1];
  assign bus.resolve_ready    = (state == IDLE);
  assign bus.redirect_valid   = redirect_valid;
  assign bus.redirect_pc      = redirect_pc;
  assign bus.flush            = flush;
  assign bus.mispredict_count = count;

  assign accept     = bus.resolve_valid & bus.resolve_ready;
  assign actual     = bus.is_jump | (bus.is_branch & bus.cmp_result);
  assign mispredict = (bus.is_branch | bus.is_jump) & (actual != bus.predicted_taken);
  assign correct_pc = actual ? bus.resolve_target : bus.resolve_pc + XLEN'(4);
  assign train      = accept & bus.is_branch & ~bus.is_jump;
  assign bht_cur    = bht[resolve_idx];

  always_comb begin
    bht_next = bht_cur;
    if (actual) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
    end
  end

  always_comb begin
    state_d          = state;
    redirect_valid_d = redirect_valid;
    redirect_pc_d    = redirect_pc;
    flush_d          = flush;
    count_d          = count;
    flush_cnt_d      = flush_cnt;
    case (state)
      IDLE: begin
        if (accept && mispredict) begin
          state_d          = REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = correct_pc;
          flush_d          = 1'b1;
          count_d          = count + 32'd1;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          redirect_valid_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            state_d     = FLUSH;
            flush_cnt_d = CNT_WIDTH'(FLUSH_CYCLES);
          end else begin
            state_d = IDLE;
            flush_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == CNT_WIDTH'(1)) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d          = IDLE;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
      end
    endcase
  end

  // Reset wins over any redirect or flush in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      count          <= '0;
      flush_cnt      <= '0;
    end else begin
      state          <= state_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      flush          <= flush_d;
      count          <= count_d;
      flush_cnt      <= flush_cnt_d;
    end
  end

  // Fetch reads the old counter value when it hits the entry being trained.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (train) begin
      bht[resolve_idx] <= bht_next;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect latency, PC wrap, handshake
// stalls, flush length, BHT saturation, jump handling and mid-redirect reset.
module tb_branch_resolve_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(
    .XLEN(32),
    .BHT_INDEX_WIDTH(6),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One accept cycle: inputs are presented in IDLE and withdrawn after the edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] tgt,
                               input logic br, input logic jmp,
                               input logic cmp, input logic pred);
    bus.resolve_pc      = pc;
    bus.resolve_target  = tgt;
    bus.is_branch       = br;
    bus.is_jump         = jmp;
    bus.cmp_result      = cmp;
    bus.predicted_taken = pred;
    bus.resolve_valid   = 1'b1;
    stepCycle();
    bus.resolve_valid   = 1'b0;
  endtask

  task automatic checkPredict(input string tag, input logic [31:0] pc, input logic exp);
    bus.fetch_pc = pc;
    #1;
    checkOutput(tag, {63'd0, bus.predict_taken}, {63'd0, exp});
  endtask

  task automatic finishRedirect();
    bus.redirect_ready = 1'b1;
    stepCycle();
    bus.redirect_ready = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("flush_done_ready", {63'd0, bus.resolve_ready}, 64'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.fetch_pc        = 32'h100;
    bus.resolve_valid   = 1'b0;
    bus.resolve_pc      = '0;
    bus.resolve_target  = '0;
    bus.is_branch       = 1'b0;
    bus.is_jump         = 1'b0;
    bus.cmp_result      = 1'b0;
    bus.predicted_taken = 1'b0;
    bus.redirect_ready  = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();

    checkPredict("rst_predict", 32'h100, 1'b0);
    checkOutput("rst_rvalid", {63'd0, bus.redirect_valid}, 64'd0);
    checkOutput("rst_rpc", {32'd0, bus.redirect_pc}, 64'd0);
    checkOutput("rst_flush", {63'd0, bus.flush}, 64'd0);
    checkOutput("rst_count", {32'd0, bus.mispredict_count}, 64'd0);
    checkOutput("rst_ready", {63'd0, bus.resolve_ready}, 64'd1);

    // Taken branch predicted not-taken at 0x100 (BHT index 0).
    applyStimulus(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("br_rvalid", {63'd0, bus.redirect_valid}, 64'd1);
    checkOutput("br_rpc", {32'd0, bus.redirect_pc}, 64'h80);
    checkOutput("br_flush", {63'd0, bus.flush}, 64'd1);
    checkOutput("br_count", {32'd0, bus.mispredict_count}, 64'd1);
    checkPredict("br_predict", 32'h100, 1'b1);

    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("hold_rvalid", {63'd0, bus.redirect_valid}, 64'd1);
      checkOutput("hold_rpc", {32'd0, bus.redirect_pc}, 64'h80);
      checkOutput("hold_flush", {63'd0, bus.flush}, 64'd1);
      checkOutput("hold_ready", {63'd0, bus.resolve_ready}, 64'd0);
    end

    bus.redirect_ready = 1'b1;
    stepCycle();
    bus.redirect_ready = 1'b0;
    checkOutput("hs_rvalid", {63'd0, bus.redirect_valid}, 64'd0);
    checkOutput("fl1_flush", {63'd0, bus.flush}, 64'd1);
    checkOutput("fl1_ready", {63'd0, bus.resolve_ready}, 64'd0);
    stepCycle();
    checkOutput("fl2_flush", {63'd0, bus.flush}, 64'd1);
    checkOutput("fl2_ready", {63'd0, bus.resolve_ready}, 64'd0);
    stepCycle();
    checkOutput("fl3_flush", {63'd0, bus.flush}, 64'd0);
    checkOutput("fl3_ready", {63'd0, bus.resolve_ready}, 64'd1);

    // Not-taken branch at the top of the address space: fall-through wraps to 0.
    applyStimulus(32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_rvalid", {63'd0, bus.redirect_valid}, 64'd1);
    checkOutput("wrap_rpc", {32'd0, bus.redirect_pc}, 64'h0);
    checkOutput("wrap_count", {32'd0, bus.mispredict_count}, 64'd2);
    finishRedirect();
    // Index 63 now at 00; one taken moves it to 01, still predicting not-taken.
    applyStimulus(32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("dec_rpc", {32'd0, bus.redirect_pc}, 64'h1234);
    checkOutput("dec_count", {32'd0, bus.mispredict_count}, 64'd3);
    checkPredict("dec_predict", 32'hFFFF_FFFC, 1'b0);
    finishRedirect();

    // Saturation at index 1: four correctly predicted taken branches.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h204, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("sat_rvalid", {63'd0, bus.redirect_valid}, 64'd0);
      checkOutput("sat_ready", {63'd0, bus.resolve_ready}, 64'd1);
      checkPredict("sat_predict", 32'h204, 1'b1);
    end
    checkOutput("sat_count", {32'd0, bus.mispredict_count}, 64'd3);
    applyStimulus(32'h204, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("nt1_rpc", {32'd0, bus.redirect_pc}, 64'h208);
    checkOutput("nt1_count", {32'd0, bus.mispredict_count}, 64'd4);
    checkPredict("nt1_predict", 32'h204, 1'b1);
    finishRedirect();
    applyStimulus(32'h204, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("nt2_count", {32'd0, bus.mispredict_count}, 64'd5);
    checkPredict("nt2_predict", 32'h204, 1'b0);
    finishRedirect();

    // Correctly predicted jump: no redirect and the BHT entry is left alone.
    applyStimulus(32'h204, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("jmp_rvalid", {63'd0, bus.redirect_valid}, 64'd0);
    checkOutput("jmp_ready", {63'd0, bus.resolve_ready}, 64'd1);
    checkOutput("jmp_count", {32'd0, bus.mispredict_count}, 64'd5);
    checkPredict("jmp_predict", 32'h204, 1'b0);

    // Non-control op with a taken prediction has no effect.
    applyStimulus(32'h204, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("nop_rvalid", {63'd0, bus.redirect_valid}, 64'd0);
    checkOutput("nop_count", {32'd0, bus.mispredict_count}, 64'd5);

    // Jump predicted not-taken redirects to the target, then reset aborts it.
    applyStimulus(32'h204, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("jmis_rvalid", {63'd0, bus.redirect_valid}, 64'd1);
    checkOutput("jmis_rpc", {32'd0, bus.redirect_pc}, 64'h400);
    checkOutput("jmis_count", {32'd0, bus.mispredict_count}, 64'd6);
    checkPredict("jmis_predict", 32'h204, 1'b0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort_rvalid", {63'd0, bus.redirect_valid}, 64'd0);
    checkOutput("abort_flush", {63'd0, bus.flush}, 64'd0);
    checkOutput("abort_count", {32'd0, bus.mispredict_count}, 64'd0);
    checkOutput("abort_ready", {63'd0, bus.resolve_ready}, 64'd1);
    checkPredict("abort_predict", 32'h100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
